// File: rtl/serdes_pkg.sv
// ============================================================================
// Module      : serdes_pkg
// Description : Shared types and constants for the serial link controller.
//               The PARITY state exists only when SERDES_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serdes_pkg;

    localparam int   FRAME_DATA_BITS = 8;
    localparam logic START_LEVEL     = 1'b0;
    localparam logic IDLE_LEVEL      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SERDES_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/serdes_rr_arb2.sv
// ============================================================================
// Module      : serdes_rr_arb2
// Description : Two-way round-robin selector with a last-grant pointer that
//               moves only when a request is actually accepted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serdes_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       accept_i,
    output logic       sel_o,
    output logic       any_o
);

    logic r_last_q;
    logic w_last_d;

    // On a tie the requester not granted last wins.
    always_comb begin
        any_o = |req_i;
        if (&req_i) begin
            sel_o = ~r_last_q;
        end else begin
            sel_o = ~req_i[0];
        end
        w_last_d = accept_i ? sel_o : r_last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last_q <= 1'b1;
        end else begin
            r_last_q <= w_last_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serdes_link_ctrl.sv
// ============================================================================
// Module      : serdes_link_ctrl
// Description : Arbitrates two byte requesters onto a UART-style serial line
//               (start, 8 data LSB first, optional even parity, stop, gap).
//               Build macro SERDES_PARITY_EN enables the parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serdes_link_ctrl
    import serdes_pkg::*;
#(
    parameter int IDLE_GAP = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic       req0_ready,
    output logic       req1_ready,
    output logic       tx_bit,
    output logic       tx_busy,
    output logic       grant_id,
    output logic       frame_done
);

    localparam logic [2:0] c_BIT_LAST = 3'(FRAME_DATA_BITS - 1);
    localparam logic [3:0] c_GAP_LAST = (IDLE_GAP == 0) ? 4'd0 : 4'(IDLE_GAP - 1);

    state_t     r_state_q, w_state_d;
    logic [7:0] r_data_q,  w_data_d;
    logic       r_grant_q, w_grant_d;
    logic [2:0] r_bitcnt_q, w_bitcnt_d;
    logic [3:0] r_gapcnt_q, w_gapcnt_d;

    logic w_sel;
    logic w_any;
    logic w_offer;
    logic w_accept;

    serdes_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_i    ({req1_valid, req0_valid}),
        .accept_i (w_accept),
        .sel_o    (w_sel),
        .any_o    (w_any)
    );

    // Ready is also gated by rst_n so nothing is accepted while reset is held.
    assign w_offer    = (r_state_q == ST_IDLE) & ena & rst_n & w_any;
    assign req0_ready = w_offer & ~w_sel;
    assign req1_ready = w_offer &  w_sel;
    assign w_accept   = req0_ready | req1_ready;

    assign tx_busy    = (r_state_q != ST_IDLE);
    assign frame_done = (r_state_q == ST_STOP);
    assign grant_id   = r_grant_q;

    always_comb begin
        w_state_d  = r_state_q;
        w_data_d   = r_data_q;
        w_grant_d  = r_grant_q;
        w_bitcnt_d = r_bitcnt_q;
        w_gapcnt_d = r_gapcnt_q;
        tx_bit     = IDLE_LEVEL;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_data_d  = w_sel ? req1_data : req0_data;
                    w_grant_d = w_sel;
                    w_state_d = ST_START;
                end
            end
            ST_START: begin
                tx_bit     = START_LEVEL;
                w_bitcnt_d = 3'd0;
                w_state_d  = ST_DATA;
            end
            ST_DATA: begin
                tx_bit     = r_data_q[r_bitcnt_q];
                w_bitcnt_d = r_bitcnt_q + 3'd1;
                if (r_bitcnt_q == c_BIT_LAST) begin
`ifdef SERDES_PARITY_EN
                    w_state_d = ST_PARITY;
`else
                    w_state_d = ST_STOP;
`endif
                end
            end
`ifdef SERDES_PARITY_EN
            ST_PARITY: begin
                tx_bit    = ^r_data_q;
                w_state_d = ST_STOP;
            end
`endif
            ST_STOP: begin
                w_gapcnt_d = 4'd0;
                w_state_d  = (IDLE_GAP == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                w_gapcnt_d = r_gapcnt_q + 4'd1;
                if (r_gapcnt_q == c_GAP_LAST) begin
                    w_state_d = ST_IDLE;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q  <= ST_IDLE;
            r_data_q   <= 8'h00;
            r_grant_q  <= 1'b0;
            r_bitcnt_q <= 3'd0;
            r_gapcnt_q <= 4'd0;
        end else begin
            r_state_q  <= w_state_d;
            r_data_q   <= w_data_d;
            r_grant_q  <= w_grant_d;
            r_bitcnt_q <= w_bitcnt_d;
            r_gapcnt_q <= w_gapcnt_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serdes_link_ctrl.sv
// ============================================================================
// Module      : tb_serdes_link_ctrl
// Description : Self-checking bench for serdes_link_ctrl against a frame-level
//               reference model (queue of expected line bits per frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serdes_link_ctrl;

    localparam int c_GAP = 1;
`ifdef SERDES_PARITY_EN
    localparam int c_PAR = 1;
`else
    localparam int c_PAR = 0;
`endif
    localparam int c_PERIOD = 11 + c_PAR + c_GAP;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       req0_valid = 1'b0;
    logic       req1_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, tx_bit, tx_busy, grant_id, frame_done;

    serdes_link_ctrl #(.IDLE_GAP(c_GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .req0_valid (req0_valid),
        .req1_valid (req1_valid),
        .req0_data  (req0_data),
        .req1_data  (req1_data),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .tx_bit     (tx_bit),
        .tx_busy    (tx_busy),
        .grant_id   (grant_id),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // One entry per future line cycle of the frame in flight.
    typedef struct {
        bit b;
        bit done;
    } fbit_t;

    fbit_t exp_q[$];
    bit    m_last  = 1'b1;
    bit    m_grant = 1'b0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int last_acc = -1;
    bit track_period = 1'b0;
    bit saw_r0, saw_r1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        exp_q.push_back('{b: 1'b0, done: 1'b0});
        for (int i = 0; i < 8; i++) exp_q.push_back('{b: d[i], done: 1'b0});
        if (c_PAR != 0) exp_q.push_back('{b: ^d, done: 1'b0});
        exp_q.push_back('{b: 1'b1, done: 1'b1});
        for (int i = 0; i < c_GAP; i++) exp_q.push_back('{b: 1'b1, done: 1'b0});
    endtask

    // Compare this cycle's outputs with the model, then advance the model by one edge.
    task automatic model_step();
        bit busy, any, win, e0, e1;
        busy = (exp_q.size() != 0);
        any  = req0_valid | req1_valid;
        win  = (req0_valid & req1_valid) ? ~m_last : ~req0_valid;
        e0   = !busy && ena && rst_n && any && (win == 1'b0);
        e1   = !busy && ena && rst_n && any && (win == 1'b1);
        saw_r0 = req0_ready;
        saw_r1 = req1_ready;
        check("req0_ready", 32'(req0_ready), 32'(e0));
        check("req1_ready", 32'(req1_ready), 32'(e1));
        check("tx_bit",     32'(tx_bit),     32'(busy ? exp_q[0].b : 1'b1));
        check("tx_busy",    32'(tx_busy),    32'(busy));
        check("frame_done", 32'(frame_done), 32'(busy && exp_q[0].done));
        if (busy) check("grant_id", 32'(grant_id), 32'(m_grant));
        if (track_period && (req0_ready | req1_ready)) begin
            if (last_acc >= 0) check("accept_period", 32'(cyc - last_acc), 32'(c_PERIOD));
            last_acc = cyc;
        end
        if (!rst_n) begin
            exp_q.delete();
            m_last  = 1'b1;
            m_grant = 1'b0;
        end else if (busy) begin
            void'(exp_q.pop_front());
        end else if (e0 || e1) begin
            m_last  = win;
            m_grant = win;
            push_frame(win ? req1_data : req0_data);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer one byte and hold it until accepted (bounded), then let the frame drain.
    task automatic send(input bit who, input logic [7:0] d);
        bit got;
        got = 1'b0;
        if (who) begin req1_valid = 1'b1; req1_data = d; end
        else     begin req0_valid = 1'b1; req0_data = d; end
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = who ? saw_r1 : saw_r0;
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        run(c_PERIOD);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_grant_id", 32'(grant_id), 32'd0);
        check("reset_tx_bit",   32'(tx_bit),   32'd1);
        run(2);
        rst_n = 1'b1;
        ena   = 1'b1;
        run(2);

        send(1'b0, 8'hFF);
        send(1'b1, 8'hA5);
        send(1'b0, 8'h07);
        send(1'b1, 8'h03);

        // Continuous ties must alternate at the frame period.
        req0_data = 8'h11; req1_data = 8'h22;
        req0_valid = 1'b1; req1_valid = 1'b1;
        track_period = 1'b1;
        last_acc = -1;
        run(4 * c_PERIOD + 2);
        track_period = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(c_PERIOD);

        // Disabled link holds off; dropping enable mid-frame lets the frame finish.
        ena = 1'b0;
        req0_valid = 1'b1; req0_data = 8'h5C;
        run(15);
        ena = 1'b1;
        for (int i = 0; i < 5 && !saw_r0; i++) tick();
        run(5);
        ena = 1'b0;
        run(2 * c_PERIOD);
        ena = 1'b1;
        run(c_PERIOD + 2);
        req0_valid = 1'b0;
        run(c_PERIOD);

        // Reset during the data bits aborts the frame; first tie afterwards goes to 0.
        req1_valid = 1'b1; req1_data = 8'h3C;
        tick();
        req1_valid = 1'b0;
        run(6);
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        run(2);
        rst_n = 1'b1;
        run(c_PERIOD + 3);
        req0_valid = 1'b0; req1_valid = 1'b0;
        run(c_PERIOD);

        for (int i = 0; i < 600; i++) begin
            ena        = ($urandom_range(0, 9) != 0);
            rst_n      = ($urandom_range(0, 149) != 0);
            req0_valid = $urandom_range(0, 1) == 1;
            req1_valid = $urandom_range(0, 1) == 1;
            req0_data  = 8'($urandom);
            req1_data  = 8'($urandom);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/serdes_link_ctrl.md
SERDES_LINK_CTRL -- requirements
Module: serdes_link_ctrl

Interface
REQ-001 Parameter IDLE_GAP, default 1, SHALL set the number of idle-high cycles inserted after each stop bit (range 0..15).
REQ-002 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ena  input  1  link enable; new frames SHALL be granted only while ena=1.
REQ-005 req0_valid, req1_valid  input  1 each  requester has a byte pending.
REQ-006 req0_data, req1_data  input  8 each  byte offered by each requester.
REQ-007 req0_ready, req1_ready  output  1 each  accept strobe; byte is taken on the edge where valid&ready=1.
REQ-008 tx_bit  output  1  serial line toward the serdes datapath; idle level 1.
REQ-009 tx_busy  output  1  high from the start bit through the last gap cycle.
REQ-010 grant_id  output  1  requester index of the frame in flight (valid while tx_busy=1).
REQ-011 frame_done  output  1  one-cycle pulse in the final cycle of the stop bit.

Function
REQ-012 FSM states: IDLE, START, DATA, PARITY (only with SERDES_PARITY_EN), STOP, GAP.
REQ-013 IDLE: req_ready SHALL be combinational = (state==IDLE) & ena & (arbiter selects that requester) & its valid; at most one ready high per cycle.
REQ-014 Arbitration: single valid wins; both valid -> requester not granted last wins (round-robin); last-grant pointer updates only on acceptance.
REQ-015 On acceptance the byte and grant_id SHALL be latched; next cycle state=START, tx_bit=0 for exactly one cycle.
REQ-016 DATA: 8 cycles, tx_bit = latched bit 0 first through bit 7 (LSB first), 3-bit bit counter.
REQ-017 STOP: one cycle, tx_bit=1, frame_done=1; then GAP for IDLE_GAP cycles (tx_bit=1), skipped when IDLE_GAP=0; then IDLE.
REQ-018 Frame period without parity SHALL be 11+IDLE_GAP cycles from one acceptance to the next when requests are continuous.
REQ-019 Requester data/valid changes after acceptance SHALL NOT affect the frame in flight.
REQ-020 ena falling mid-frame: current frame SHALL complete unchanged; no grant afterwards until ena=1.
REQ-021 In IDLE, tx_bit=1, tx_busy=0, frame_done=0.

Reset
REQ-022 rst_n=0 at a clock edge SHALL force state=IDLE, tx_bit=1, tx_busy=0, frame_done=0, grant_id=0, bit counter=0, gap counter=0, last-grant pointer=1 (requester 0 wins first tie).
REQ-023 Reset asserted mid-frame SHALL abort the frame; the aborted byte is not retransmitted and no ready is issued during reset.

Configuration
REQ-024 Macro SERDES_PARITY_EN defined: PARITY state inserted between DATA bit 7 and STOP, one cycle, tx_bit = XOR of the 8 data bits (even parity); frame period 12+IDLE_GAP.
REQ-025 Macro SERDES_PARITY_EN undefined: no PARITY state, no parity logic; DATA bit 7 is followed directly by STOP.

Structure
REQ-026 Shared package serdes_pkg SHALL hold the FSM state enum, FRAME_DATA_BITS=8, START_LEVEL=0, IDLE_LEVEL=1.
REQ-027 Sub-module serdes_rr_arb2 SHALL implement the 2-way round-robin select and last-grant pointer; FSM and shifter stay in serdes_link_ctrl.

Verification
REQ-028 Reset then ena=1, req0 sends 0xFF -> tx_bit: 0, 1x8, 1(stop); frame_done once; req0_ready one cycle.
REQ-029 req1 sends 0xA5 -> tx_bit sequence 0,1,0,1,0,0,1,0,1,1; grant_id=1 throughout tx_busy.
REQ-030 Both valid continuously (0x11, 0x22), IDLE_GAP=1 -> grants alternate 0,1,0,1; accept strobes 12 cycles apart.
REQ-031 ena=0 with req0_valid=1 -> no ready, tx_bit stays 1; ena dropped at DATA bit 3 -> frame finishes, next grant waits for ena=1.
REQ-032 rst_n=0 during DATA bit 4 -> next cycle tx_bit=1, tx_busy=0; after release, tie resolves to requester 0.
REQ-033 SERDES_PARITY_EN, byte 0x07 -> parity bit 1 between bit 7 and stop; byte 0x03 -> parity bit 0; period 13 cycles with IDLE_GAP=1.
